instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch responder for the single-cycle RV32I core: it takes the core's `pc` and returns a 32-bit `instruction`, stalling the core while it assembles the word from a byte-wide instruction memory over four handshaked beats. It sits between the core's `pc`/`instruction` pins and the instruction memory port. A one-entry hit buffer can return a repeated fetch of the same word without touching memory.

## Interface
- `NOP`, default 32'h00000013, value driven on `instruction` after reset and on a misaligned fetch.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  fetch address from the core.
- `fetch_en`  in  1  core requests the instruction at `pc`.
- `instruction`  out  32  assembled instruction word to the core.
- `instr_valid`  out  1  `instruction` is the word at the current `pc`; the core may advance.
- `stall`  out  1  combinational: `fetch_en & ~instr_valid`.
- `misaligned`  out  1  one-cycle pulse when `pc[1:0]` is nonzero.
- `mem_req`  out  1  memory beat request.
- `mem_addr`  out  32  byte address of the current beat.
- `mem_ack`  in  1  beat accepted; `mem_rdata` is valid in this cycle.
- `mem_rdata`  in  8  returned byte.

## Operation
- FSM states: IDLE, FETCH, DONE, ERR.
- **IDLE**, when `fetch_en` is 1:
  - If `pc[1:0]` is not 0, go to ERR.
  - Else on a buffer hit (tag valid and `pc == tag`), go to DONE.
  - Else latch `pc` into `pc_lat`, clear the beat counter, and go to FETCH.
- **FETCH**:
  - `mem_req` is 1 and `mem_addr = {pc_lat[31:2],2'b00} + beat`.
  - On a cycle with `mem_ack = 1`, store `mem_rdata` into byte lane `beat` (little-endian: beat 0 is bits [7:0]) and increment `beat`.
  - `mem_ack` on beat 3 loads the assembled word into `instruction`, sets tag to `pc_lat`, sets tag valid, and moves to DONE.
  - A cycle without `mem_ack` holds the beat, address and `mem_req`.
- **DONE**:
  - `instr_valid = fetch_en & (pc == tag)`.
  - Always returns to IDLE next cycle.
- **ERR**:
  - `instruction <= NOP`, `misaligned = 1`, `instr_valid = fetch_en`.
  - Returns to IDLE next cycle.
- `mem_req` is 0 in every state except FETCH.
- Boundary rules:
  - `pc` changes mid-fetch: the fetch completes for `pc_lat` and the buffer is updated. In DONE, `instr_valid` stays 0 because `pc` no longer matches. The next IDLE cycle starts a new fetch.
  - `fetch_en` drops mid-fetch: the memory transaction is never abandoned. The fetch completes with no valid in DONE.
  - `mem_addr` is computed in 32 bits and does not wrap within a word, since beats only add 0–3 to an aligned base.
  - Reset mid-fetch: FSM goes to IDLE and `mem_req` drops immediately (asynchronously). Partial bytes are discarded and tag valid is cleared.

## Timing
- Reset values:
  - State = IDLE, `instruction` = `NOP`, tag valid = 0, beat = 0.
  - `instr_valid` = 0, `misaligned` = 0, `mem_req` = 0, `mem_addr` = 0.
  - `stall` follows `fetch_en`.
- Miss latency, with `mem_ack` high every cycle: `fetch_en` sampled in IDLE at cycle 0; FETCH during cycles 1–4; DONE with `instr_valid = 1` in cycle 5.
- Each memory wait cycle adds one cycle.
- Hit latency: DONE with `instr_valid` in cycle 1.
- Misaligned latency: ERR with `misaligned` and `instr_valid` in cycle 1.
- `instr_valid` and `misaligned` are never high for more than one consecutive cycle per request.
- Minimum issue rate is one instruction every 2 cycles on hits.

## Configuration
- `IFU_HIT_BUFFER_EN` defined: tag and tag valid are implemented, and hits bypass memory as described above.
- `IFU_HIT_BUFFER_EN` undefined:
  - No tag storage; every aligned request from IDLE goes to FETCH.
  - DONE uses `pc == pc_lat` for `instr_valid`.
  - Interface and all other timing are unchanged.

## Test plan
- Reset, then `pc = 0x0` with `fetch_en = 1`; memory returns bytes 93,00,80,3e with ack every cycle. Required:
  - `mem_addr` is 0,1,2,3 on successive cycles.
  - `instruction = 32'h3e800093` with `instr_valid = 1` in cycle 5.
  - `stall` is high in cycles 0–4.
- `pc = 0x4`, bytes 13,01,00,83, with `mem_ack` low for 2 cycles on beat 1. Required: `mem_addr` holds at 0x5 while ack is low; `instruction = 32'h83000113` in cycle 7.
- Request `pc = 0x4` again right after that fetch. Required:
  - With `IFU_HIT_BUFFER_EN`: `instr_valid` in cycle 1 and `mem_req` never asserted.
  - Without it: the request takes the full 5-cycle refetch.
- `pc = 0x6` with `fetch_en = 1`. Required: `misaligned = 1` and `instruction = 32'h00000013` in cycle 1, with no `mem_req`.
- `pc` changes from 0x8 to 0xC during beat 2. Required: no `instr_valid` in DONE, then a new fetch starts with `mem_addr = 0xC`.
- Assert `rst` during beat 2. Required: `mem_req` falls the same cycle, `instruction = 32'h00000013`, and a following fetch of the same `pc` misses.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: assembles 32-bit instructions from a byte-wide memory over four handshaked beats.
// Optional one-entry hit buffer enabled by defining IFU_HIT_BUFFER_EN.
module instr_fetch_unit #(
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_en,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [29:0] pc_lat_q, pc_lat_d;
    logic [1:0]  beat_q, beat_d;
    logic [23:0] bytes_q, bytes_d;
    logic [31:0] instr_q, instr_d;
    logic [29:0] match_hi;
    logic        hit;
    logic        start_fetch;
    logic        last_beat;

`ifdef IFU_HIT_BUFFER_EN
    logic [29:0] tag_q, tag_d;
    logic [31:0] word_q, word_d;
    logic        tag_vld_q, tag_vld_d;

    assign hit      = tag_vld_q && pc == {tag_q, 2'b00};
    assign match_hi = tag_q;
`else
    assign hit      = 1'b0;
    assign match_hi = pc_lat_q;
`endif

    assign start_fetch = state_q == IDLE && fetch_en && pc[1:0] == 2'b00 && !hit;
    assign last_beat   = state_q == FETCH && mem_ack && beat_q == 2'd3;
    assign instruction = instr_q;

    // State and datapath registers; reset discards partial bytes and the buffer tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_lat_q  <= '0;
            beat_q    <= '0;
            bytes_q   <= '0;
            instr_q   <= NOP;
`ifdef IFU_HIT_BUFFER_EN
            tag_q     <= '0;
            word_q    <= '0;
            tag_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_lat_q  <= pc_lat_d;
            beat_q    <= beat_d;
            bytes_q   <= bytes_d;
            instr_q   <= instr_d;
`ifdef IFU_HIT_BUFFER_EN
            tag_q     <= tag_d;
            word_q    <= word_d;
            tag_vld_q <= tag_vld_d;
`endif
        end
    end

    // Next-state logic: misaligned wins over hit, hit wins over a memory fetch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = pc[1:0] != 2'b00 ? ERR : hit ? DONE : FETCH;
            FETCH:   if (last_beat) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Beat collection and instruction word update; the word is loaded on entry to DONE/ERR.
    always_comb begin
        pc_lat_d = pc_lat_q;
        beat_d   = beat_q;
        bytes_d  = bytes_q;
        instr_d  = instr_q;
        if (start_fetch) begin
            pc_lat_d = pc[31:2];
            beat_d   = 2'd0;
        end
        if (state_q == FETCH && mem_ack) begin
            beat_d  = beat_q + 2'd1;
            bytes_d = {beat_q == 2'd2 ? mem_rdata : bytes_q[23:16],
                       beat_q == 2'd1 ? mem_rdata : bytes_q[15:8],
                       beat_q == 2'd0 ? mem_rdata : bytes_q[7:0]};
        end
        if (last_beat) instr_d = {mem_rdata, bytes_q};
        if (state_q == IDLE && fetch_en && pc[1:0] != 2'b00) instr_d = NOP;
`ifdef IFU_HIT_BUFFER_EN
        if (state_q == IDLE && fetch_en && pc[1:0] == 2'b00 && hit) instr_d = word_q;
`endif
    end

`ifdef IFU_HIT_BUFFER_EN
    // Hit buffer keeps its own copy of the word so a misaligned NOP cannot corrupt later hits.
    always_comb begin
        tag_d     = tag_q;
        word_d    = word_q;
        tag_vld_d = tag_vld_q;
        if (last_beat) begin
            tag_d     = pc_lat_q;
            word_d    = {mem_rdata, bytes_q};
            tag_vld_d = 1'b1;
        end
    end
`endif

    // Outputs decoded from the current state; mem_req drops as soon as reset clears the state.
    always_comb begin
        mem_req     = state_q == FETCH;
        mem_addr    = mem_req ? {pc_lat_q, 2'b00} + {30'd0, beat_q} : 32'd0;
        misaligned  = state_q == ERR;
        instr_valid = state_q == DONE ? fetch_en && pc == {match_hi, 2'b00}
                                      : misaligned && fetch_en;
        stall       = fetch_en && !instr_valid;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized scoreboard bench for instr_fetch_unit with a byte-memory responder.
module tb_instr_fetch_unit;
    localparam logic [31:0] NOP = 32'h00000013;
`ifdef IFU_HIT_BUFFER_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    typedef struct {
        logic [31:0] word;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic        fetch_en = 1'b0;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        stall;
    logic        misaligned;
    logic        mem_req;
    logic [31:0] mem_addr;

    logic [7:0]  mem [256];
    int          vectors = 0;
    int          miscompares = 0;
    int          acks = 0;
    int          waits = 0;
    int          ack_pct = 100;
    logic [31:0] hold_addr = '1;
    int          hold_cnt = 0;
    logic [31:0] addr_log [$];
    exp_t        sb [$];
    bit          tag_v = 1'b0;
    logic [31:0] tag = '0;
    logic        prev_v = 1'b0;
    logic        prev_m = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
        .instruction(instruction), .instr_valid(instr_valid), .stall(stall),
        .misaligned(misaligned), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    // Byte memory: answers each cycle, with optional forced wait cycles on one address.
    always @(posedge clk) begin
        #2;
        if (mem_req && mem_addr == hold_addr && hold_cnt > 0) begin
            mem_ack = 1'b0;
            hold_cnt--;
        end else begin
            mem_ack = $urandom_range(99) < ack_pct;
        end
        mem_rdata = mem[mem_addr[7:0]];
    end

    // Monitor: per-cycle protocol checks and scoreboard pop on every valid.
    always @(negedge clk) begin
        exp_t e;
        check("stall", 32'(stall), 32'(fetch_en & ~instr_valid));
        if (mem_req) begin
            addr_log.push_back(mem_addr);
            check("beat_lane", 32'(mem_addr[1:0]), 32'(acks[1:0]));
            if (mem_ack) acks++;
            else waits++;
        end
        if (instr_valid) begin
            check("valid_pulse", 32'(prev_v), 32'd0);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_valid: instruction %h with nothing expected", instruction);
            end else begin
                e = sb.pop_front();
                check("instruction", instruction, e.word);
                check("misaligned", 32'(misaligned), 32'(e.mis));
            end
        end
        if (misaligned) check("mis_pulse", 32'(prev_m), 32'd0);
        prev_v = instr_valid;
        prev_m = misaligned;
    end

    task automatic req(input logic [31:0] a);
        logic mis, hit;
        exp_t e;
        int a0, w0, cyc;
        mis = a[1:0] != 2'b00;
        hit = HB && !mis && tag_v && tag == a;
        @(posedge clk);
        #1;
        pc = a;
        fetch_en = 1'b1;
        e.word = mis ? NOP : word_at(a);
        e.mis = mis;
        sb.push_back(e);
        a0 = acks;
        w0 = waits;
        cyc = -1;
        do begin
            @(negedge clk);
            cyc++;
        end while (!instr_valid && cyc < 80);
        check("latency", cyc, (mis || hit) ? 32'd1 : 32'(5 + waits - w0));
        check("beats", acks - a0, (mis || hit) ? 32'd0 : 32'd4);
        if (!mis && !hit) begin
            tag = a;
            tag_v = 1'b1;
        end
    endtask

    task automatic idle(input int k);
        @(posedge clk);
        #1;
        fetch_en = 1'b0;
        repeat (k) @(posedge clk);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == a) && n < 40);
        check("reach_addr", mem_addr, a);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] last_pc, a;
        exp_t e;
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        {mem[3], mem[2], mem[1], mem[0]} = 32'h3e800093;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h83000113;

        fetch_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_instruction", instruction, NOP);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        fetch_en = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;

        addr_log.delete();
        req(32'h0);
        check("t1_naddr", addr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) check("t1_addr", addr_log[i], 32'(i));
        idle(1);

        hold_addr = 32'h5;
        hold_cnt = 2;
        addr_log.delete();
        req(32'h4);
        check("t2_naddr", addr_log.size(), 32'd6);
        if (addr_log.size() == 6) begin
            check("t2_addr0", addr_log[0], 32'h4);
            check("t2_addr1", addr_log[1], 32'h5);
            check("t2_addr2", addr_log[2], 32'h5);
            check("t2_addr3", addr_log[3], 32'h5);
            check("t2_addr5", addr_log[5], 32'h7);
        end

        addr_log.delete();
        req(32'h4);
        check("t3_naddr", addr_log.size(), HB ? 32'd0 : 32'd4);
        idle(1);

        req(32'h6);
        idle(1);

        addr_log.delete();
        @(posedge clk);
        #1;
        pc = 32'h8;
        fetch_en = 1'b1;
        wait_addr(32'hA);
        #1;
        pc = 32'hC;
        e.word = word_at(32'hC);
        e.mis = 1'b0;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_naddr", addr_log.size(), 32'd8);
        if (addr_log.size() == 8) check("t5_newaddr", addr_log[4], 32'hC);
        tag = 32'hC;
        tag_v = 1'b1;
        idle(1);

        req(32'h10);
        idle(1);
        @(posedge clk);
        #1;
        pc = 32'h14;
        fetch_en = 1'b1;
        wait_addr(32'h16);
        #1 rst = 1'b1;
        #1;
        check("t6_mem_req", 32'(mem_req), 32'd0);
        check("t6_instruction", instruction, NOP);
        check("t6_mem_addr", mem_addr, 32'd0);
        fetch_en = 1'b0;
        acks = 0;
        waits = 0;
        tag_v = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        req(32'h10);
        idle(1);

        ack_pct = 70;
        last_pc = 32'h10;
        repeat (60) begin
            n = $urandom_range(9);
            if (n < 3) a = last_pc;
            else if (n == 3) a = 32'($urandom_range(63)) * 4 + 32'($urandom_range(1, 3));
            else a = 32'($urandom_range(63)) * 4;
            req(a);
            last_pc = a;
            if ($urandom_range(1) == 1) idle($urandom_range(2));
        end
        idle(3);
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
